// File: rtl/rotary_dial_encoder.sv
// rotary_dial_encoder: quadrature encoder decoder for the vault controller.
// Two-flop synchroniser, debounce, Gray-step decode, detent accumulator and
// a wrapping 0..CODE_MAX dial position. Optional zero button: DIAL_ZERO_EN.
module rotary_dial_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned STEPS_PER_DETENT = 4,
  parameter int unsigned CODE_MAX         = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
`ifdef DIAL_ZERO_EN
  input  logic       zero_btn,
`endif
  output logic       direction,
  output logic [4:0] vault_code,
  output logic       step_pulse,
  output logic       quad_error
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [2:0] SUB_MAX = 3'(STEPS_PER_DETENT - 1);
  localparam logic [5:0] CODE_MAX_6 = 6'(CODE_MAX);

  typedef enum logic [1:0] {
    MOVE_NONE    = 2'd0,
    MOVE_CW      = 2'd1,
    MOVE_ILLEGAL = 2'd2,
    MOVE_CCW     = 2'd3
  } move_e;

  // Position of an A/B level along the clockwise cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  logic [1:0]        ab_s1_q, ab_sync_q;
  logic [1:0]        ab_db_q, ab_db_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [2:0] sub_q, sub_d;
  logic [4:0]        code_q, code_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              err_q, err_d;
  logic              accept;
  move_e             move;
  logic [5:0]        code_up;
  logic [4:0]        code_next_up, code_next_dn;

`ifdef DIAL_ZERO_EN
  logic zero_s1_q, zero_sync_q, zero_prev_q;
  logic zero_edge;
  assign zero_edge = zero_sync_q & ~zero_prev_q;

  // Synchronise the zero button and remember its last level for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      zero_s1_q   <= 1'b0;
      zero_sync_q <= 1'b0;
      zero_prev_q <= 1'b0;
    end else begin
      zero_s1_q   <= zero_btn;
      zero_sync_q <= zero_s1_q;
      zero_prev_q <= zero_sync_q;
    end
  end
`endif

  // Step the dial up/down with the wrap done in 6 bits against CODE_MAX.
  assign move         = move_e'(gray_pos(ab_sync_q) - gray_pos(ab_db_q));
  assign code_up      = {1'b0, code_q} + 6'd1;
  assign code_next_up = (code_up > CODE_MAX_6) ? 5'd0 : code_up[4:0];
  assign code_next_dn = (code_q == 5'd0) ? CODE_MAX_6[4:0] : code_q - 5'd1;

  // Debounce, transition decode and detent accumulation.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    ab_db_d = ab_db_q;
    cnt_d   = '0;
    sub_d   = sub_q;
    code_d  = code_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;

    if (ab_sync_q != ab_db_q) begin
      if (cnt_q == CNT_LAST) begin
        accept  = 1'b1;
        ab_db_d = ab_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (accept) begin
      case (move)
        MOVE_CW: begin
          if (sub_q == SUB_MAX) begin
            sub_d  = '0;
            code_d = code_next_up;
            dir_d  = 1'b1;
            step_d = 1'b1;
          end else begin
            sub_d = sub_q + 3'sd1;
          end
        end
        MOVE_CCW: begin
          if (sub_q == -SUB_MAX) begin
            sub_d  = '0;
            code_d = code_next_dn;
            dir_d  = 1'b0;
            step_d = 1'b1;
          end else begin
            sub_d = sub_q - 3'sd1;
          end
        end
        MOVE_ILLEGAL: begin
          sub_d = '0;
          err_d = 1'b1;
        end
        default: ;
      endcase
    end

`ifdef DIAL_ZERO_EN
    // Zeroing beats a coincident detent: no pulse, direction kept.
    if (zero_edge) begin
      code_d = 5'd0;
      sub_d  = '0;
      dir_d  = dir_q;
      step_d = 1'b0;
    end
`endif
  end

  // State and registered outputs; reset returns everything to the idle 11 level.
  always_ff @(posedge clock) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      ab_s1_q   <= 2'b11;
      ab_sync_q <= 2'b11;
      ab_db_q   <= 2'b11;
      cnt_q     <= '0;
      sub_q     <= '0;
      code_q    <= 5'd0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ab_s1_q   <= {quad_a, quad_b};
      ab_sync_q <= ab_s1_q;
      ab_db_q   <= ab_db_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      code_q    <= code_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign direction  = dir_q;
  assign vault_code = code_q;
  assign step_pulse = step_q;
  assign quad_error = err_q;

endmodule

// File: tb/tb_rotary_dial_encoder.sv
// Scoreboard bench for rotary_dial_encoder: a level-based encoder model queues
// expected strobes (kind, cycle, code, direction); a negedge monitor pops them.
module tb_rotary_dial_encoder;

  localparam int D  = 4;
  localparam int S  = 4;
  localparam int CM = 31;

  logic       clock = 1'b0;
  logic       reset;
  logic       quad_a, quad_b;
  logic       direction;
  logic [4:0] vault_code;
  logic       step_pulse, quad_error;
`ifdef DIAL_ZERO_EN
  logic       zero_btn;
`endif

  rotary_dial_encoder #(
    .DEBOUNCE_CYCLES (D),
    .STEPS_PER_DETENT(S),
    .CODE_MAX        (CM)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
`ifdef DIAL_ZERO_EN
    .zero_btn  (zero_btn),
`endif
    .direction (direction),
    .vault_code(vault_code),
    .step_pulse(step_pulse),
    .quad_error(quad_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_err;
    int code;
    bit dir;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_sub, m_code, m_pulses, seen_pulses = 0;
  bit   m_dir;
  logic [1:0] m_ab;
  int   pos_tab[4] = '{0, 1, 3, 2};              // index = {a,b}
  logic [1:0] ab_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Encoder model: classify a level change by its distance around the CW cycle.
  task automatic model_move(input logic [1:0] from_ab, input logic [1:0] to_ab, input int at_cyc);
    int   d;
    exp_t e;
    d = (pos_tab[to_ab] - pos_tab[from_ab] + 4) % 4;
    if (d == 1) begin
      if (m_sub == S - 1) begin
        m_sub = 0; m_code = (m_code + 1) % (CM + 1); m_dir = 1'b1; m_pulses++;
        e = '{is_err: 1'b0, code: m_code, dir: m_dir, cyc: at_cyc};
        exp_q.push_back(e);
      end else m_sub++;
    end else if (d == 3) begin
      if (m_sub == -(S - 1)) begin
        m_sub = 0; m_code = (m_code + CM) % (CM + 1); m_dir = 1'b0; m_pulses++;
        e = '{is_err: 1'b0, code: m_code, dir: m_dir, cyc: at_cyc};
        exp_q.push_back(e);
      end else m_sub--;
    end else if (d == 2) begin
      m_sub = 0;
      e = '{is_err: 1'b1, code: m_code, dir: m_dir, cyc: at_cyc};
      exp_q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called just after an edge; a change made now is first sampled next edge.
  task automatic drive(input logic [1:0] ab, input int hold);
    if (ab != m_ab) model_move(m_ab, ab, cyc + 2 + D);
    {quad_a, quad_b} = ab;
    m_ab = ab;
    tick(hold);
  endtask

  task automatic step_cw(input int hold);
    drive(ab_tab[(pos_tab[m_ab] + 1) % 4], hold);
  endtask

  task automatic step_ccw(input int hold);
    drive(ab_tab[(pos_tab[m_ab] + 3) % 4], hold);
  endtask

  task automatic detent(input bit cw);
    for (int i = 0; i < S; i++) begin
      if (cw) step_cw(10); else step_ccw(10);
    end
  endtask

  task automatic glitch(input int g);
    quad_a = ~m_ab[1];
    tick(g);
    quad_a = m_ab[1];
    tick(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {quad_a, quad_b} = 2'b11;
    tick(3);
    reset = 1'b0;
    m_sub = 0; m_code = 0; m_dir = 1'b0; m_ab = 2'b11;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_code"}, vault_code, m_code);
    check({tag, "_dir"}, direction, m_dir);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      check("strobe_exclusive", int'(step_pulse & quad_error), 0);
      if (step_pulse || quad_error) begin
        if (step_pulse) seen_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", int'({step_pulse, quad_error}), 0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_err", quad_error, e.is_err);
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_code", vault_code, e.code);
          check("strobe_dir", direction, e.dir);
        end
      end
    end
  end

  initial begin
    int p0;
    int r;
`ifdef DIAL_ZERO_EN
    int n0;
    zero_btn = 1'b0;
`endif
    m_pulses = 0;
    do_reset();
    check("reset_code", vault_code, 0);
    check("reset_dir", direction, 0);
    check("reset_step", step_pulse, 0);
    check("reset_err", quad_error, 0);

    // One clockwise detent 11->10->00->01->11.
    detent(1'b1);
    tick(5);
    check_state("cw1");
    check("cw1_pulses", seen_pulses, 1);

    // Reset mid-detent discards the partial rotation.
    step_cw(10);
    step_cw(10);
    do_reset();
    check_state("midreset");

    // CCW from 0 wraps to CODE_MAX, then 32 CW detents come back round.
    detent(1'b0);
    check_state("ccw_wrap");
    p0 = seen_pulses;
    for (int i = 0; i < 32; i++) detent(1'b1);
    tick(5);
    check_state("cw32");
    check("cw32_pulses", seen_pulses - p0, 32);

    // Short glitches are rejected.
    glitch(2);
    glitch(1);
    glitch(D - 1);
    check_state("glitch");

    // Reversal mid-detent: sub walks back to zero, no pulse.
    p0 = seen_pulses;
    step_cw(10); step_cw(10); step_ccw(10); step_ccw(10);
    tick(5);
    check("reversal_pulses", seen_pulses - p0, 0);
    check_state("reversal");

    // Illegal jump 11->00, then a full CW detent from 00.
    drive(2'b00, 10);
    check_state("illegal");
    detent(1'b1);
    tick(5);
    check_state("after_illegal");

`ifdef DIAL_ZERO_EN
    while (m_code != 17) detent(1'b1);
    tick(5);
    check_state("pre_zero");
    n0 = cyc;
    zero_btn = 1'b1;
    tick(2);
    check("zero_not_yet", vault_code, 17);
    tick(1);
    check("zero_cycle", cyc - n0, 3);
    check("zero_code", vault_code, 0);
    check("zero_dir", direction, m_dir);
    m_code = 0; m_sub = 0;
    tick(17);
    zero_btn = 1'b0;
    tick(3);
    detent(1'b1);
    tick(5);
    check_state("after_zero");
`endif

    // Randomised encoder activity against the model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      step_cw($urandom_range(D + 2, 12));
      else if (r < 90) step_ccw($urandom_range(D + 2, 12));
      else if (r < 95) drive(ab_tab[(pos_tab[m_ab] + 2) % 4], $urandom_range(D + 2, 12));
      else             glitch($urandom_range(1, D - 1));
    end

    tick(20);
    check("scoreboard_drained", exp_q.size(), 0);
    check_state("final");
    check("total_pulses", seen_pulses, m_pulses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
